uart_rx_data: RTL and testbench
===============================

# uart_rx_data

Serial receiver for the 1-start / 8-data (LSB first) / 1-stop frame that the team's TX_Data block emits on TXD. The block synchronises the incoming line and samples each bit at its centre. It returns the assembled byte with a complete/clear handshake that mirrors the transmitter's tx_complete_flag / tx_complete_del_flag pair, and it flags framing errors and overruns. It sits at the receive pin of the link, in the same clk domain as the transmitter. With CLKS_PER_BIT = 1 it receives TX_Data frames directly, including frames sent back-to-back with no idle gap.

## Interface
- CLKS_PER_BIT, default 1: clk cycles per serial bit; legal range is ≥1; M = (CLKS_PER_BIT-1)/2 is the mid-bit sample offset.
- DATA_W, default 8: data bits per frame.
- clk  in  1  rising-edge clock.
- reset_n  in  1  reset; asynchronous, active-low.
- RXD  in  1  serial line, idle high; asynchronous to clk.
- rx_complete_del_flag  in  1  consumer acknowledge; clears rx_complete_flag, frame_error and overrun.
- DATA_OUT  out  DATA_W  last good byte; holds its value until the next good frame.
- rx_busy  out  1  high while a frame is in progress.
- rx_complete_flag  out  1  sticky; a new good byte is available.
- frame_error  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a good byte arrived while rx_complete_flag was still set.

## Operation
- RXD passes through a 2-FF synchroniser. Both flops reset to 1. rxd_s is the synchronised line.
- The FSM has five states: IDLE, START_BIT, DATA_RX, STOP_BIT, WAIT_IDLE.
- IDLE:
  - When rxd_s = 0, the start bit is detected and the bit-cycle counter is cleared.
  - If M = 0, the start bit is treated as confirmed and the FSM goes directly to DATA_RX.
  - Otherwise the FSM goes to START_BIT.
- START_BIT:
  - At count M, if rxd_s = 0, the FSM goes to DATA_RX.
  - At count M, if rxd_s = 1, this is a false start: the FSM returns to IDLE and no flag changes.
- DATA_RX:
  - Samples rxd_s every CLKS_PER_BIT cycles.
  - Shifts each sample into the MSB of the shift register, so data ends up LSB first.
  - After DATA_W samples, the FSM goes to STOP_BIT.
- STOP_BIT: at the sample point (CLKS_PER_BIT cycles after the last data sample):
  - If rxd_s = 1: DATA_OUT <= shift register; rx_complete_flag <= 1; overrun <= 1 if rx_complete_flag was already 1 and is not being cleared in the same cycle. The FSM goes to IDLE.
  - If rxd_s = 0: frame_error <= 1; DATA_OUT and rx_complete_flag are unchanged; the FSM goes to WAIT_IDLE.
- WAIT_IDLE: the FSM stays here until rxd_s = 1, then goes to IDLE. This prevents a break condition from being decoded as repeated frames.
- rx_busy = 1 in START_BIT, DATA_RX and STOP_BIT. It is a registered output, updated on the same edge as the state transition.
- Acknowledge: rx_complete_del_flag = 1 clears all three sticky flags on the next edge. If a set and a clear hit the same flag in the same cycle, the set wins.
- Bit-cycle counter width is clog2(CLKS_PER_BIT) (minimum 1). Bit index width is clog2(DATA_W+1). Both counters return to 0 in IDLE.

## Timing
- Reset values:
  - DATA_OUT = 0.
  - rx_busy = 0.
  - rx_complete_flag = 0.
  - frame_error = 0.
  - overrun = 0.
  - State = IDLE.
  - Synchroniser flops = 1.
- Edge E is the clk edge after which a bit first appears on RXD. That bit is sampled on edge E + 3 + M: two synchroniser edges plus one FSM register edge.
- rx_complete_flag and DATA_OUT update on edge S + 3 + M, where S is the edge at which the stop bit begins.
  - Example, CLKS_PER_BIT = 1: a start bit beginning at edge E gives rx_complete_flag high after edge E + 12.
- Back-to-back frames: after the stop sample the FSM is in IDLE on the next edge and can detect a start bit immediately. Zero idle bits between frames are supported at every CLKS_PER_BIT.
- Reset asserted mid-frame: all state and outputs return to their reset values immediately. The partial frame is discarded.
- A glitch low shorter than M+1 cycles is rejected as a false start. This case exists only for CLKS_PER_BIT ≥ 3.

## Structure
- Shared package uart_pkg holds:
  - The rx_state_t enum (IDLE, START_BIT, DATA_RX, STOP_BIT, WAIT_IDLE).
  - The DATA_W default.
  - The frame constants START_LVL = 0 and STOP_LVL = 1, which are shared with the transmitter.
- One natural sub-module: uart_sync2, a 2-FF synchroniser with an asynchronous reset to 1. It is reused by other pin inputs.
- The FSM, counters and shift register remain in uart_rx_data.

## Test plan
- Single frame 0xA5, CLKS_PER_BIT = 1, driven by TX_Data → DATA_OUT = 0xA5, rx_complete_flag rises 12 edges after the start bit, frame_error = 0, overrun = 0.
- Frames 0x3C then 0xC3 with zero gap, acknowledge pulsed after each → both bytes received in order, no frame_error, no overrun.
- Frame 0x55 with the stop bit forced to 0, then the line held low for 20 cycles → frame_error = 1, DATA_OUT unchanged, state stays WAIT_IDLE until RXD rises, no spurious frames.
- CLKS_PER_BIT = 16, a 4-cycle low glitch, then a valid 0x81 frame → glitch ignored, 0x81 received, flags clean.
- Two good frames 0x11 and 0x22, no acknowledge → DATA_OUT = 0x22, overrun = 1; an acknowledge pulse clears all flags; an acknowledge coinciding with a third completion leaves rx_complete_flag = 1.
- reset_n pulsed low after the 4th data bit of 0xF0, then 0x0F sent → all outputs return to reset values immediately, then 0x0F is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter and the receiver.
//   rx_state_t     : receiver FSM state encoding
//   DATA_W_DEFAULT : default number of data bits per frame
//   START_LVL      : line level of the start bit
//   STOP_LVL       : line level of the stop bit (also the idle level)
//   cnt_width()    : width of a counter that must hold 0..n-1 (minimum 1)
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int   DATA_W_DEFAULT = 8;
  localparam logic START_LVL      = 1'b0;
  localparam logic STOP_LVL       = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START_BIT,
    DATA_RX,
    STOP_BIT,
    WAIT_IDLE
  } rx_state_t;

  // A counter for n states needs clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_data_if.sv
// ---------------------------------------------------------------------------
// uart_rx_data_if
// Consumer-side bundle of the UART receiver.
//   rx_complete_del_flag : consumer -> receiver, acknowledge / clear flags
//   DATA_OUT             : receiver -> consumer, last good byte
//   rx_busy              : receiver -> consumer, frame in progress
//   rx_complete_flag     : receiver -> consumer, sticky new-byte flag
//   frame_error          : receiver -> consumer, sticky bad-stop flag
//   overrun              : receiver -> consumer, sticky overrun flag
// master = receiver, slave = consumer.
// ---------------------------------------------------------------------------
interface uart_rx_data_if
  import uart_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
);

  logic              rx_complete_del_flag;
  logic [DATA_W-1:0] DATA_OUT;
  logic              rx_busy;
  logic              rx_complete_flag;
  logic              frame_error;
  logic              overrun;

  modport master (
    input  rx_complete_del_flag,
    output DATA_OUT,
    output rx_busy,
    output rx_complete_flag,
    output frame_error,
    output overrun
  );

  modport slave (
    output rx_complete_del_flag,
    input  DATA_OUT,
    input  rx_busy,
    input  rx_complete_flag,
    input  frame_error,
    input  overrun
  );

endinterface

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for an asynchronous pin input. Both flops reset to
// the UART idle level so a line that is idle during reset produces no edge
// when reset is released.
//   clk     : destination clock
//   reset_n : asynchronous, active-low reset
//   i_async : asynchronous input
//   o_sync  : synchronised output (two clk edges of latency)
// ---------------------------------------------------------------------------
module uart_sync2
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_sync
);

  logic r_meta;
  logic r_sync;

  // First flop may go metastable; the second gives it a full cycle to settle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= STOP_LVL;
      r_sync <= STOP_LVL;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_data.sv
// ---------------------------------------------------------------------------
// uart_rx_data
// Serial receiver for 1 start / DATA_W data (LSB first) / 1 stop frames.
// The line is synchronised, each bit is sampled at its centre, and the byte
// is returned with a sticky complete flag that the consumer clears with
// rx_complete_del_flag. Bad stop bits raise frame_error; a good byte landing
// on an unacknowledged one raises overrun.
//   CLKS_PER_BIT : clk cycles per serial bit (>= 1)
//   DATA_W       : data bits per frame
//   clk          : rising-edge clock
//   reset_n      : asynchronous, active-low reset
//   RXD          : serial line, idle high, asynchronous to clk
//   bus          : consumer handshake (uart_rx_data_if.master)
// ---------------------------------------------------------------------------
module uart_rx_data
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_W       = DATA_W_DEFAULT
)(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           RXD,
  uart_rx_data_if.master bus
);

  // Mid-bit sample offset, measured from the start-bit detection edge.
  localparam int M  = (CLKS_PER_BIT - 1) / 2;
  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(M);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

  logic w_rxd_s;
  logic w_ack;

  rx_state_t         r_state;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_busy;
  logic              r_complete;
  logic              r_ferr;
  logic              r_ovr;

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (RXD),
    .o_sync  (w_rxd_s)
  );

  assign w_ack = bus.rx_complete_del_flag;

  // Receiver FSM with counters, shift register and all registered outputs.
  // The acknowledge clears the sticky flags first; any set later in this
  // block overrides the clear, so a set in the same cycle wins.
  // The detection edge counts as the first cycle of the start bit, which is
  // why START_BIT is entered with the counter already at one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_shift    <= '0;
      r_data     <= '0;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
      r_ferr     <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      if (w_ack) begin
        r_complete <= 1'b0;
        r_ferr     <= 1'b0;
        r_ovr      <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (w_rxd_s == START_LVL) begin
            r_busy <= 1'b1;
            if (M == 0) begin
              r_state <= DATA_RX;
            end else begin
              r_state <= START_BIT;
              r_cnt   <= CNT_ONE;
            end
          end
        end

        START_BIT: begin
          if (r_cnt == CNT_MID) begin
            r_cnt <= '0;
            if (w_rxd_s == START_LVL) begin
              r_state <= DATA_RX;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        DATA_RX: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {w_rxd_s, r_shift[DATA_W-1:1]};
            if (r_idx == IDX_LAST) begin
              r_state <= STOP_BIT;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        STOP_BIT: begin
          if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            if (w_rxd_s == STOP_LVL) begin
              r_state    <= IDLE;
              r_data     <= r_shift;
              r_complete <= 1'b1;
              if (r_complete && !w_ack) begin
                r_ovr <= 1'b1;
              end
            end else begin
              r_state <= WAIT_IDLE;
              r_ferr  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        WAIT_IDLE: begin
          r_cnt <= '0;
          r_idx <= '0;
          if (w_rxd_s == STOP_LVL) begin
            r_state <= IDLE;
          end
        end

        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.DATA_OUT         = r_data;
  assign bus.rx_busy          = r_busy;
  assign bus.rx_complete_flag = r_complete;
  assign bus.frame_error      = r_ferr;
  assign bus.overrun          = r_ovr;

endmodule

// File: tb/tb_uart_rx_data.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_data
// Self-checking bench for uart_rx_data. Two receivers run side by side, one
// at CLKS_PER_BIT = 1 (index 0) and one at CLKS_PER_BIT = 16 (index 1). A
// frame-level model predicts byte and flag values per receiver.
// ---------------------------------------------------------------------------
module tb_uart_rx_data;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic rxd1;
  logic rxd16;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  logic [7:0] mData     [2];
  logic       mComplete [2];
  logic       mFerr     [2];
  logic       mOvr      [2];

  always #5 clk = ~clk;

  // Edge counter used for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_data_if #(.DATA_W(8)) bus1 ();
  uart_rx_data_if #(.DATA_W(8)) bus16 ();

  uart_rx_data #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .RXD     (rxd1),
    .bus     (bus1)
  );

  uart_rx_data #(.CLKS_PER_BIT(16), .DATA_W(8)) dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .RXD     (rxd16),
    .bus     (bus16)
  );

  // Safety net so a stuck run still ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int cpbOf(input int w);
    return (w == 0) ? 1 : 16;
  endfunction

  function automatic logic [7:0] dataOf(input int w);
    return (w == 0) ? bus1.DATA_OUT : bus16.DATA_OUT;
  endfunction

  function automatic logic completeOf(input int w);
    return (w == 0) ? bus1.rx_complete_flag : bus16.rx_complete_flag;
  endfunction

  function automatic logic ferrOf(input int w);
    return (w == 0) ? bus1.frame_error : bus16.frame_error;
  endfunction

  function automatic logic ovrOf(input int w);
    return (w == 0) ? bus1.overrun : bus16.overrun;
  endfunction

  function automatic logic busyOf(input int w);
    return (w == 0) ? bus1.rx_busy : bus16.rx_busy;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkDut(input int w, input string tag);
    checkOutput($sformatf("%s.data%0d", tag, w), 32'(dataOf(w)), 32'(mData[w]));
    checkOutput($sformatf("%s.complete%0d", tag, w), 32'(completeOf(w)), 32'(mComplete[w]));
    checkOutput($sformatf("%s.ferr%0d", tag, w), 32'(ferrOf(w)), 32'(mFerr[w]));
    checkOutput($sformatf("%s.ovr%0d", tag, w), 32'(ovrOf(w)), 32'(mOvr[w]));
    checkOutput($sformatf("%s.busy%0d", tag, w), 32'(busyOf(w)), 32'd0);
  endtask

  // Frame-level model: a good frame delivers its byte and raises the
  // complete flag; it is an overrun if an unacknowledged byte was pending.
  // A bad stop only raises frame_error. A same-cycle acknowledge loses to
  // any flag being set but clears the others.
  task automatic modelFrame(input int w, input logic [7:0] b, input logic stopOk, input logic ackSame);
    if (stopOk) begin
      if (mComplete[w] && !ackSame) mOvr[w] = 1'b1;
      else if (ackSame)             mOvr[w] = 1'b0;
      mData[w]     = b;
      mComplete[w] = 1'b1;
      if (ackSame) mFerr[w] = 1'b0;
    end else begin
      mFerr[w] = 1'b1;
      if (ackSame) begin
        mComplete[w] = 1'b0;
        mOvr[w]      = 1'b0;
      end
    end
  endtask

  task automatic modelClearAll(input int w, input logic wipeData);
    mComplete[w] = 1'b0;
    mFerr[w]     = 1'b0;
    mOvr[w]      = 1'b0;
    if (wipeData) mData[w] = 8'h00;
  endtask

  task automatic setLine(input int w, input logic v);
    if (w == 0) rxd1 = v;
    else        rxd16 = v;
  endtask

  task automatic setAck(input int w, input logic v);
    if (w == 0) bus1.rx_complete_del_flag = v;
    else        bus16.rx_complete_del_flag = v;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveBit(input int w, input logic v);
    setLine(w, v);
    stepCycles(cpbOf(w));
  endtask

  // Sends one frame starting just after the current edge; returns just after
  // the edge that ends the stop bit, leaving the line at the stop level.
  task automatic applyStimulus(input int w, input logic [7:0] b, input logic stopLvl);
    driveBit(w, START_LVL);
    for (int i = 0; i < 8; i++) driveBit(w, b[i]);
    driveBit(w, stopLvl);
  endtask

  task automatic pulseAck(input int w);
    setAck(w, 1'b1);
    stepCycles(1);
    setAck(w, 1'b0);
    modelClearAll(w, 1'b0);
  endtask

  task automatic settle(input int w);
    setLine(w, STOP_LVL);
    stepCycles(cpbOf(w) + 6);
  endtask

  initial begin
    int startCyc;
    int riseCyc;
    logic [7:0] b;
    int w;
    logic stopOk;

    reset_n = 1'b0;
    rxd1    = 1'b1;
    rxd16   = 1'b1;
    bus1.rx_complete_del_flag  = 1'b0;
    bus16.rx_complete_del_flag = 1'b0;
    modelClearAll(0, 1'b1);
    modelClearAll(1, 1'b1);

    // Reset state.
    #1;
    checkDut(0, "reset");
    checkDut(1, "reset");
    stepCycles(3);
    reset_n = 1'b1;
    stepCycles(2);

    // 0xA5 at one clock per bit: completion exactly 12 edges after start.
    startCyc = cyc;
    applyStimulus(0, 8'hA5, STOP_LVL);
    modelFrame(0, 8'hA5, 1'b1, 1'b0);
    riseCyc = -1;
    for (int k = 0; k < 20 && riseCyc < 0; k++) begin
      if (bus1.rx_complete_flag) riseCyc = cyc;
      else stepCycles(1);
    end
    checkOutput("a5.latency", 32'(riseCyc - startCyc), 32'd12);
    settle(0);
    checkDut(0, "a5");
    pulseAck(0);

    // 0x3C and 0xC3 back to back, acknowledging the first mid-flight.
    fork
      begin
        applyStimulus(0, 8'h3C, STOP_LVL);
        applyStimulus(0, 8'hC3, STOP_LVL);
      end
      begin
        stepCycles(13);
        modelFrame(0, 8'h3C, 1'b1, 1'b0);
        checkOutput("b2b.first", 32'(bus1.DATA_OUT), 32'(mData[0]));
        checkOutput("b2b.firstflag", 32'(bus1.rx_complete_flag), 32'(mComplete[0]));
        pulseAck(0);
      end
    join
    modelFrame(0, 8'hC3, 1'b1, 1'b0);
    settle(0);
    checkDut(0, "b2b");
    pulseAck(0);

    // 0x55 with a low stop bit, then a break held for 20 cycles.
    applyStimulus(0, 8'h55, ~STOP_LVL);
    modelFrame(0, 8'h55, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      stepCycles(1);
      if (k % 4 == 3) begin
        checkOutput($sformatf("break.ferr.%0d", k), 32'(bus1.frame_error), 32'(mFerr[0]));
        checkOutput($sformatf("break.busy.%0d", k), 32'(bus1.rx_busy), 32'd0);
        checkOutput($sformatf("break.complete.%0d", k), 32'(bus1.rx_complete_flag), 32'(mComplete[0]));
      end
    end
    settle(0);
    checkDut(0, "break");
    pulseAck(0);
    checkDut(0, "breakack");

    // Short glitch at 16 clocks per bit, then a real 0x81 frame.
    setLine(1, START_LVL);
    stepCycles(4);
    setLine(1, STOP_LVL);
    stepCycles(30);
    checkDut(1, "glitch");
    applyStimulus(1, 8'h81, STOP_LVL);
    modelFrame(1, 8'h81, 1'b1, 1'b0);
    settle(1);
    checkDut(1, "g81");
    pulseAck(1);

    // Overrun, clear, and an acknowledge colliding with a completion.
    applyStimulus(0, 8'h11, STOP_LVL);
    modelFrame(0, 8'h11, 1'b1, 1'b0);
    settle(0);
    applyStimulus(0, 8'h22, STOP_LVL);
    modelFrame(0, 8'h22, 1'b1, 1'b0);
    settle(0);
    checkDut(0, "ovr");
    pulseAck(0);
    checkDut(0, "ovrack");
    applyStimulus(0, 8'h33, STOP_LVL);
    modelFrame(0, 8'h33, 1'b1, 1'b0);
    settle(0);
    applyStimulus(0, 8'h44, STOP_LVL);
    stepCycles(1);
    setAck(0, 1'b1);
    stepCycles(1);
    setAck(0, 1'b0);
    modelFrame(0, 8'h44, 1'b1, 1'b1);
    settle(0);
    checkDut(0, "collide");
    pulseAck(0);

    // Random frames on either receiver, some with bad stops and acks.
    for (int n = 0; n < 12; n++) begin
      w      = int'($urandom_range(0, 1));
      b      = 8'($urandom);
      stopOk = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 2) == 0) pulseAck(w);
      applyStimulus(w, b, stopOk ? STOP_LVL : ~STOP_LVL);
      modelFrame(w, b, stopOk, 1'b0);
      settle(w);
      checkDut(w, $sformatf("rnd%0d", n));
    end

    // Reset in the middle of 0xF0, then 0x0F.
    pulseAck(0);
    applyStimulus(0, 8'h5A, STOP_LVL);
    modelFrame(0, 8'h5A, 1'b1, 1'b0);
    settle(0);
    b = 8'hF0;
    driveBit(0, START_LVL);
    for (int i = 0; i < 4; i++) driveBit(0, b[i]);
    checkOutput("rst.busybefore", 32'(bus1.rx_busy), 32'd1);
    #2;
    reset_n = 1'b0;
    rxd1    = 1'b1;
    modelClearAll(0, 1'b1);
    modelClearAll(1, 1'b1);
    #1;
    checkDut(0, "rst");
    checkDut(1, "rst");
    stepCycles(2);
    reset_n = 1'b1;
    stepCycles(2);
    applyStimulus(0, 8'h0F, STOP_LVL);
    modelFrame(0, 8'h0F, 1'b1, 1'b0);
    settle(0);
    checkDut(0, "after");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
